// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv input path: FSM states, lane count
// derivation and the default counter width.
package conv_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int LEN_WIDTH_DEFAULT = 32;

   function automatic int lanes(input int io_width, input int elem_width);
      return io_width / elem_width;
   endfunction

endpackage

// File: rtl/beat_fifo.sv
// Two-entry synchronous FIFO with registered full/empty flags and a
// synchronous flush that drops everything held.
module beat_fifo #(
   parameter int WIDTH = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Flags only change on an unbalanced push/pop; a simultaneous pair keeps the occupancy.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (do_push && !do_pop) begin
            empty <= 1'b0;
            full  <= !empty;
         end else if (do_pop && !do_push) begin
            full  <= 1'b0;
            empty <= !full;
         end
      end
   end

endmodule

// File: rtl/stream_lane_unpacker.sv
// Accepts wide packed beats and emits one element per cycle, lane 0 first,
// for a frame of frame_len elements requested by start.
module stream_lane_unpacker
   import conv_pkg::*;
#(
   parameter int IO_DATA_WIDTH = 48,
   parameter int ELEM_WIDTH    = 16,
   parameter int LEN_WIDTH     = LEN_WIDTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_WIDTH-1:0]     frame_len,
   input  logic [IO_DATA_WIDTH-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [ELEM_WIDTH-1:0]    out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic [LEN_WIDTH-1:0]     out_index,
   output logic                     busy
);

   localparam int LANES = lanes(IO_DATA_WIDTH, ELEM_WIDTH);
   localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(LANES - 1);

   state_e                   state_q;
   state_e                   state_next;
   logic [LEN_WIDTH-1:0]     len_q;
   logic [LEN_WIDTH:0]       acc_q;
   logic [LEN_WIDTH-1:0]     idx_q;
   logic [PTR_W-1:0]         ptr_q;

   logic                     fifo_full;
   logic                     fifo_empty;
   logic [IO_DATA_WIDTH-1:0] head;
   logic [ELEM_WIDTH-1:0]    lane_sel;
   logic                     run;
   logic                     start_ok;
   logic                     push;
   logic                     out_hs;
   logic                     last_hs;
   logic                     pop;

   assign run      = (state_q == RUN);
   assign start_ok = start && (frame_len != '0);
   assign busy     = run;

   // acc is one bit wider than len so a full final beat can never wrap it.
   assign in_ready  = run && !fifo_full && (acc_q < {1'b0, len_q});
   assign push      = in_valid && in_ready;
   assign out_valid = run && !fifo_empty;
   assign out_last  = out_valid && (idx_q == (len_q - LEN_WIDTH'(1)));
   assign out_index = idx_q;
   assign out_hs    = out_valid && out_ready;
   assign last_hs   = out_hs && out_last;
   assign pop       = out_hs && ((ptr_q == PTR_MAX) || out_last);

   always_comb begin
      lane_sel = '0;
      for (int k = 0; k < LANES; k++) begin
         if (ptr_q == PTR_W'(k)) begin
            lane_sel = head[k*ELEM_WIDTH +: ELEM_WIDTH];
         end
      end
   end

   assign out_data = out_valid ? lane_sel : '0;

   // Completing the frame flushes any beats fetched beyond frame_len.
   beat_fifo #(
      .WIDTH (IO_DATA_WIDTH)
   ) u_beat_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (last_hs),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_next;
      end
   end

   always_comb begin
      state_next = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_next = RUN;
         RUN:     if (last_hs) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q <= '0;
         acc_q <= '0;
         idx_q <= '0;
         ptr_q <= '0;
      end else if (state_q == IDLE) begin
         if (start_ok) begin
            len_q <= frame_len;
            acc_q <= '0;
            idx_q <= '0;
            ptr_q <= '0;
         end
      end else begin
         if (push) begin
            acc_q <= acc_q + (LEN_WIDTH + 1)'(LANES);
         end
         if (last_hs) begin
            idx_q <= '0;
            ptr_q <= '0;
         end else if (out_hs) begin
            idx_q <= idx_q + LEN_WIDTH'(1);
            ptr_q <= pop ? '0 : ptr_q + PTR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_stream_lane_unpacker.sv
// Directed bench for stream_lane_unpacker: expected elements are queued when a
// frame is requested and a monitor pops and compares on every output handshake.
module tb_stream_lane_unpacker;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] frame_len;
   logic [47:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [31:0] out_index;
   logic        busy;

   logic [48:0] exp_q[$];
   int          pop_cyc[$];
   int          n_cmp;
   int          n_fail;
   int          cyc;
   int          accept_cyc;
   int          ready_mode;

   stream_lane_unpacker #(
      .IO_DATA_WIDTH (48),
      .ELEM_WIDTH    (16),
      .LEN_WIDTH     (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .frame_len (frame_len),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_index (out_index),
      .busy      (busy)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [48:0] pack_elem(input logic [15:0] d, input logic [31:0] i, input logic l);
      return {d, i, l};
   endfunction

   // out_ready driver: 0 = always 1, 1 = pattern 1,0,0, 2 = held 0, 3 = driven by main
   initial begin
      int ph;
      ph = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = (ph == 0);
               ph = (ph == 2) ? 0 : ph + 1;
            end
            2: out_ready = 1'b0;
            default: ;
         endcase
      end
   end

   // scoreboard monitor
   initial begin
      logic        prev_v;
      logic        prev_r;
      logic [48:0] prev_w;
      logic [48:0] cur_w;
      logic [48:0] exp_w;
      prev_v = 1'b0;
      prev_r = 1'b0;
      prev_w = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            cur_w = pack_elem(out_data, out_index, out_last);
            if (out_valid) begin
               if (prev_v && !prev_r) begin
                  check("hold_stable", cur_w, prev_w);
               end
               if (out_ready) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_output", cur_w, 49'h0);
                  end else begin
                     exp_w = exp_q.pop_front();
                     check("elem{data,idx,last}", cur_w, exp_w);
                     pop_cyc.push_back(cyc);
                  end
               end
            end
            prev_v = out_valid;
            prev_r = out_ready;
            prev_w = cur_w;
         end
      end
   end

   // driver tasks
   task automatic start_frame(input logic [31:0] len);
      start     = 1'b1;
      frame_len = len;
      @(posedge clk);
      #1;
      start     = 1'b0;
   endtask

   task automatic expect_frame(input logic [15:0] first, input int len);
      for (int i = 0; i < len; i++) begin
         exp_q.push_back(pack_elem(first + 16'(i), 32'(i), i == len - 1));
      end
   endtask

   task automatic send_beat(input logic [47:0] d);
      bit done;
      done     = 1'b0;
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            accept_cyc = cyc;
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!done) check("beat_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (exp_q.size() == 0) done = 1'b1;
         else @(posedge clk);
      end
      #1;
      if (!done) check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      n_cmp      = 0;
      n_fail     = 0;
      ready_mode = 0;
      rst        = 1'b1;
      start      = 1'b0;
      frame_len  = '0;
      in_data    = '0;
      in_valid   = 1'b0;
      accept_cyc = 0;

      // reset state
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_out_index", 64'(out_index), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // basic frame, full rate
      pop_cyc.delete();
      expect_frame(16'd1, 6);
      start_frame(32'd6);
      send_beat(48'h0003_0002_0001);
      begin
         int first_accept;
         first_accept = accept_cyc;
         send_beat(48'h0006_0005_0004);
         wait_drain();
         check("basic_latency", 64'(pop_cyc[0]), 64'(first_accept + 1));
      end
      check("basic_throughput", 64'(pop_cyc[5] - pop_cyc[0]), 64'd5);
      @(negedge clk);
      check("basic_busy_falls", 64'(busy), 64'd0);

      // partial final beat
      @(posedge clk);
      #1;
      expect_frame(16'd1, 4);
      start_frame(32'd4);
      send_beat(48'h0003_0002_0001);
      send_beat(48'h0006_0005_0004);
      in_data  = 48'h0009_0008_0007;
      in_valid = 1'b1;
      @(negedge clk);
      check("partial_in_ready_low", 64'(in_ready), 64'd0);
      wait_drain();
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("partial_no_extra", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;

      // back-pressure
      ready_mode = 2;
      expect_frame(16'd1, 9);
      start_frame(32'd9);
      send_beat(48'h0003_0002_0001);
      send_beat(48'h0006_0005_0004);
      in_data  = 48'h0009_0008_0007;
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_full_in_ready", 64'(in_ready), 64'd0);
      check("bp_stalled_data", 64'(out_data), 64'd1);
      ready_mode = 1;
      send_beat(48'h0009_0008_0007);
      wait_drain();
      ready_mode = 0;
      repeat (3) @(posedge clk);
      #1;

      // ignored starts
      start_frame(32'd0);
      @(negedge clk);
      check("zero_len_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      expect_frame(16'd7, 3);
      start_frame(32'd3);
      @(negedge clk);
      check("run_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      start_frame(32'd5);
      send_beat(48'h0009_0008_0007);
      wait_drain();
      @(negedge clk);
      check("restart_ignored_idle", 64'(busy), 64'd0);
      @(posedge clk);
      #1;

      // reset mid-frame
      ready_mode = 2;
      expect_frame(16'd1, 6);
      start_frame(32'd6);
      send_beat(48'h0003_0002_0001);
      send_beat(48'h0006_0005_0004);
      ready_mode = 3;
      out_ready  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_out_index", 64'(out_index), 64'd0);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      ready_mode = 0;
      out_ready  = 1'b1;
      expect_frame(16'd10, 3);
      start_frame(32'd3);
      send_beat(48'h000C_000B_000A);
      wait_drain();
      @(posedge clk);
      #1;

      // idle input is not consumed
      in_data  = 48'h0063_0062_0061;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      expect_frame(16'd13, 3);
      start_frame(32'd3);
      send_beat(48'h000F_000E_000D);
      wait_drain();

      repeat (5) @(posedge clk);
      #1;
      check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
